// File: rtl/hufftree_build_ctrl_pkg.sv
// rtl/hufftree_build_ctrl_pkg.sv - shared types, constants and helpers for the Huffman tree build controller
// Purpose: sizing helper, FSM state encoding and table write-data field offsets.
// Ports: none (package).
package hufftree_build_ctrl_pkg;

   // Number of bits needed to hold the values 0..n-1 (ceil(log2(n))).
   function automatic int ceil_log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   localparam int HUFF_CODE_LEN_DEF = 8;
   localparam int TIMEOUT_CYC_DEF   = 4096;
   localparam int NUM_W             = 6;
   localparam int CODE_W            = 5;

   // tbl_wdata = {valid, len, code}; the valid bit sits directly above len.
   localparam int WD_CODE_LSB = 0;
   localparam int WD_LEN_LSB  = WD_CODE_LSB + CODE_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LAUNCH,
      ST_BUILD,
      ST_NEXT,
      ST_DONE,
      ST_ERR
   } state_e;

endpackage

// File: rtl/hufftree_build_ctrl_tbl_clr.sv
// rtl/hufftree_build_ctrl_tbl_clr.sv - sequential clear-address generator for a lookup table
// Purpose: walks addresses 0..2^ADDR_W-1, one per cycle, after a start pulse.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start_i    - restart the sweep at address 0 (first address is presented next cycle)
//   addr_o     - current clear address
//   last_o     - high while the final address of the sweep is presented
module hufftree_build_ctrl_tbl_clr #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

   logic [ADDR_W:0] cnt_q;
   logic            act_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         act_q <= 1'b0;
      end else if (start_i) begin
         cnt_q <= '0;
         act_q <= 1'b1;
      end else if (act_q) begin
         cnt_q <= cnt_q + (ADDR_W+1)'(1);
         if (cnt_q == LAST_ADDR) act_q <= 1'b0;
      end
   end

   assign addr_o = cnt_q[ADDR_W-1:0];
   assign last_o = act_q && (cnt_q == LAST_ADDR);

endmodule

// File: rtl/hufftree_build_ctrl.sv
// rtl/hufftree_build_ctrl.sv - dynamic Huffman table build sequencer for the inflate core
// Purpose: per tree (lit/len, then optional dist) clear the lookup table, launch the
//          tree generator, forward its writes and detect completion, over-subscription and hang.
// Ports:
//   clk, rst_n                         - clock, asynchronous active-low reset
//   start, lit_*, dist_en, dist_*      - job request and per-tree config (sampled in IDLE)
//   busy, done, err                    - job status (err is sticky until next accepted start)
//   gen_inc, gen_tree_num, gen_bias    - generator launch interface
//   gen_done, gen_winc, gen_addr/len/code - generator return and write interface
//   tbl_we, tbl_sel, tbl_addr, tbl_wdata  - lookup table write port, wdata = {valid, len, code}
module hufftree_build_ctrl
   import hufftree_build_ctrl_pkg::*;
#(
   parameter int HUFF_CODE_LEN = HUFF_CODE_LEN_DEF,
   parameter int HUFF_LEN_LEN  = ceil_log2(HUFF_CODE_LEN + 1),
   parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [NUM_W-1:0]               lit_num,
   input  logic [NUM_W-1:0]               lit_bias,
   input  logic                           dist_en,
   input  logic [NUM_W-1:0]               dist_num,
   input  logic [NUM_W-1:0]               dist_bias,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic                           gen_inc,
   output logic [NUM_W-1:0]               gen_tree_num,
   output logic [NUM_W-1:0]               gen_bias,
   input  logic                           gen_done,
   input  logic                           gen_winc,
   input  logic [HUFF_CODE_LEN-1:0]       gen_addr,
   input  logic [HUFF_LEN_LEN-1:0]        gen_len,
   input  logic [CODE_W-1:0]              gen_code,
   output logic                           tbl_we,
   output logic                           tbl_sel,
   output logic [HUFF_CODE_LEN-1:0]       tbl_addr,
   output logic [HUFF_LEN_LEN+CODE_W:0]   tbl_wdata
);

   localparam int WD_VALID_BIT = WD_LEN_LSB + HUFF_LEN_LEN;
   localparam int TO_W         = ceil_log2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]          TO_LIMIT  = TO_W'(TIMEOUT_CYC);
   localparam logic [HUFF_CODE_LEN:0]   TBL_DEPTH = {1'b1, {HUFF_CODE_LEN{1'b0}}};

   state_e                  state_q, state_d;
   logic                    t_q, t_d;
   logic [NUM_W-1:0]        lit_num_q, lit_bias_q, dist_num_q, dist_bias_q;
   logic                    dist_en_q;
   logic [HUFF_CODE_LEN:0]  wcnt_q;
   logic [TO_W-1:0]         to_q;
   logic [TO_W-1:0]         to_inc;
   logic                    busy_q, done_q, err_q, gen_inc_q, sel_q;
   logic [NUM_W-1:0]        gen_tree_num_q, gen_bias_q;

   logic                    clr_start;
   logic                    clr_last;
   logic [HUFF_CODE_LEN-1:0] clr_addr;
   logic [NUM_W-1:0]        cur_num, cur_bias;
   logic                    wcnt_full;

   hufftree_build_ctrl_tbl_clr #(
      .ADDR_W (HUFF_CODE_LEN)
   ) u_tbl_clr (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (clr_start),
      .addr_o  (clr_addr),
      .last_o  (clr_last)
   );

   assign cur_num   = t_q ? dist_num_q  : lit_num_q;
   assign cur_bias  = t_q ? dist_bias_q : lit_bias_q;
   assign wcnt_full = (wcnt_q == TBL_DEPTH);
   assign to_inc    = to_q + TO_W'(1);

   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      clr_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_CLEAR;
               t_d       = 1'b0;
               clr_start = 1'b1;
            end
         end
         ST_CLEAR: begin
            // An empty tree keeps its freshly cleared (all-invalid) table.
            if (clr_last) state_d = (cur_num == '0) ? ST_NEXT : ST_LAUNCH;
         end
         ST_LAUNCH: state_d = ST_BUILD;
         ST_BUILD: begin
            // Over-subscription outranks gen_done; a same-cycle final write still lands.
            if (gen_winc && wcnt_full)  state_d = ST_ERR;
            else if (gen_done)          state_d = ST_NEXT;
            else if (to_inc == TO_LIMIT) state_d = ST_ERR;
         end
         ST_NEXT: begin
            if (!t_q && dist_en_q) begin
               state_d   = ST_CLEAR;
               t_d       = 1'b1;
               clr_start = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         t_q            <= 1'b0;
         lit_num_q      <= '0;
         lit_bias_q     <= '0;
         dist_num_q     <= '0;
         dist_bias_q    <= '0;
         dist_en_q      <= 1'b0;
         wcnt_q         <= '0;
         to_q           <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         gen_inc_q      <= 1'b0;
         sel_q          <= 1'b0;
         gen_tree_num_q <= '0;
         gen_bias_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;

         if (state_q == ST_IDLE && start) begin
            lit_num_q   <= lit_num;
            lit_bias_q  <= lit_bias;
            dist_num_q  <= dist_num;
            dist_bias_q <= dist_bias;
            dist_en_q   <= dist_en;
            err_q       <= 1'b0;
         end

         if (state_q == ST_LAUNCH) begin
            // The timeout count includes the launch cycle, so ERR lands
            // exactly TIMEOUT_CYC cycles after gen_inc.
            to_q   <= TO_W'(1);
            wcnt_q <= '0;
         end else if (state_q == ST_BUILD) begin
            to_q <= to_inc;
            if (gen_winc && !wcnt_full) wcnt_q <= wcnt_q + (HUFF_CODE_LEN+1)'(1);
         end

         if (state_d == ST_ERR) err_q <= 1'b1;

         // Outputs are registered from the next state so they align with it.
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_DONE) || (state_d == ST_ERR);
         gen_inc_q <= (state_d == ST_LAUNCH);
         sel_q     <= (state_d == ST_CLEAR || state_d == ST_LAUNCH || state_d == ST_BUILD) ? t_d : 1'b0;
         if (state_d == ST_LAUNCH || state_d == ST_BUILD) begin
            gen_tree_num_q <= cur_num;
            gen_bias_q     <= cur_bias;
         end else begin
            gen_tree_num_q <= '0;
            gen_bias_q     <= '0;
         end
      end
   end

   // Table write port: clear sweep in CLEAR, zero-latency generator pass-through in BUILD.
   always_comb begin
      tbl_we    = 1'b0;
      tbl_addr  = '0;
      tbl_wdata = '0;
      if (state_q == ST_CLEAR) begin
         tbl_we   = 1'b1;
         tbl_addr = clr_addr;
      end else if (state_q == ST_BUILD) begin
         tbl_we                                  = gen_winc && !wcnt_full;
         tbl_addr                                = gen_addr;
         tbl_wdata[WD_CODE_LSB +: CODE_W]        = gen_code;
         tbl_wdata[WD_LEN_LSB +: HUFF_LEN_LEN]   = gen_len;
         tbl_wdata[WD_VALID_BIT]                 = 1'b1;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign gen_inc      = gen_inc_q;
   assign gen_tree_num = gen_tree_num_q;
   assign gen_bias     = gen_bias_q;
   assign tbl_sel      = sel_q;

endmodule

// File: tb/tb_hufftree_build_ctrl.sv
// tb/tb_hufftree_build_ctrl.sv - scoreboard bench for hufftree_build_ctrl
module tb_hufftree_build_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, dist_en;
   logic [5:0] lit_num, lit_bias, dist_num, dist_bias;
   logic       busy, done, err, gen_inc;
   logic [5:0] gen_tree_num, gen_bias;
   logic       gen_done, gen_winc;
   logic [7:0] gen_addr;
   logic [3:0] gen_len;
   logic [4:0] gen_code;
   logic       tbl_we, tbl_sel;
   logic [7:0] tbl_addr;
   logic [9:0] tbl_wdata;

   hufftree_build_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .lit_num(lit_num), .lit_bias(lit_bias), .dist_en(dist_en),
      .dist_num(dist_num), .dist_bias(dist_bias),
      .busy(busy), .done(done), .err(err),
      .gen_inc(gen_inc), .gen_tree_num(gen_tree_num), .gen_bias(gen_bias),
      .gen_done(gen_done), .gen_winc(gen_winc), .gen_addr(gen_addr),
      .gen_len(gen_len), .gen_code(gen_code),
      .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int gen_inc_cyc = 0, done_cyc = 0, sel1_clr_cyc = 0, gd_cyc = 0;

   logic [18:0] wr_q[$];   // {sel, addr, wdata}
   logic [11:0] gi_q[$];   // {tree_num, bias}
   logic        dn_q[$];   // expected err at done

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pops expectations whenever the DUT presents a write, launch or done.
   initial begin
      logic [18:0] ew;
      logic [11:0] eg;
      logic        ed;
      logic        prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (tbl_we) begin
            checks++;
            if (wr_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write sel=%0d addr=%0d wdata=%h required no write", tbl_sel, tbl_addr, tbl_wdata);
            end else begin
               ew = wr_q.pop_front();
               if ({tbl_sel, tbl_addr, tbl_wdata} !== ew) begin
                  errors++;
                  $display("FAIL tbl_write got sel=%0d addr=%0d wdata=%h required sel=%0d addr=%0d wdata=%h",
                           tbl_sel, tbl_addr, tbl_wdata, ew[18], ew[17:10], ew[9:0]);
               end
            end
            if (tbl_sel && tbl_addr == 8'd0 && tbl_wdata == 10'd0) sel1_clr_cyc = cyc;
         end
         if (gen_inc) begin
            checks++;
            gen_inc_cyc = cyc;
            if (gi_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_gen_inc num=%0d bias=%0d required none", gen_tree_num, gen_bias);
            end else begin
               eg = gi_q.pop_front();
               if ({gen_tree_num, gen_bias} !== eg) begin
                  errors++;
                  $display("FAIL gen_inc_cfg got num=%0d bias=%0d required num=%0d bias=%0d",
                           gen_tree_num, gen_bias, eg[11:6], eg[5:0]);
               end
            end
         end
         if (done) begin
            checks++;
            done_cyc = cyc;
            if (dn_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done err=%0d required none", err);
            end else begin
               ed = dn_q.pop_front();
               if (err !== ed) begin
                  errors++;
                  $display("FAIL done_err got %0d required %0d", err, ed);
               end
            end
         end
         if (prev_done) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL busy_after_done got %0d required 0", busy);
            end
         end
         prev_done = done;
      end
   end

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic push_clear(input logic sel);
      for (int i = 0; i < 256; i++) wr_q.push_back({sel, 8'(i), 10'h000});
   endtask

   task automatic push_writes(input logic sel, input int n, input logic [3:0] len);
      for (int i = 0; i < n; i++) wr_q.push_back({sel, 8'(i), 1'b1, len, 5'(i)});
   endtask

   task automatic do_start(input logic [5:0] ln, input logic [5:0] lb, input logic de,
                           input logic [5:0] dn, input logic [5:0] db);
      lit_num = ln; lit_bias = lb; dist_en = de; dist_num = dn; dist_bias = db;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Generator model: waits for gen_inc, then issues nwr writes; gen_done rides the last write.
   task automatic gen_run(input int nwr, input logic [3:0] len, input bit fin,
                          input logic [5:0] enum_v, input logic [5:0] ebias);
      int k;
      k = 0;
      while (!gen_inc && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (!gen_inc) begin
         checks++;
         errors++;
         $display("FAIL gen_inc_wait got none required pulse");
         return;
      end
      @(posedge clk); #1;
      for (int i = 0; i < nwr; i++) begin
         gen_winc = 1'b1;
         gen_addr = 8'(i);
         gen_len  = len;
         gen_code = 5'(i);
         gen_done = fin && (i == nwr - 1);
         if (gen_done) gd_cyc = cyc;
         check("build_tree_num", int'(gen_tree_num), int'(enum_v));
         check("build_bias", int'(gen_bias), int'(ebias));
         @(posedge clk); #1;
      end
      if (nwr == 0 && fin) begin
         gen_done = 1'b1;
         gd_cyc = cyc;
         @(posedge clk); #1;
      end
      gen_winc = 1'b0;
      gen_done = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int k;
      k = 0;
      while (!done && k < max) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL done_wait got no pulse required pulse within %0d cycles", max);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int t0_gd;
      rst_n = 1'b0; start = 1'b0; dist_en = 1'b0;
      lit_num = '0; lit_bias = '0; dist_num = '0; dist_bias = '0;
      gen_done = 1'b0; gen_winc = 1'b0; gen_addr = '0; gen_len = '0; gen_code = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", int'({busy, done, err, gen_inc, gen_tree_num, gen_bias, tbl_we, tbl_sel, tbl_addr, tbl_wdata}), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single tree, 4 writes of len 2; stray generator strobes during CLEAR are ignored.
      push_clear(1'b0); gi_q.push_back({6'd4, 6'd3}); push_writes(1'b0, 4, 4'd2); dn_q.push_back(1'b0);
      do_start(6'd4, 6'd3, 1'b0, 6'd0, 6'd0);
      repeat (5) @(posedge clk);
      #1; gen_winc = 1'b1; gen_done = 1'b1; gen_addr = 8'hAA; gen_len = 4'd7; gen_code = 5'd9;
      @(posedge clk); #1; gen_winc = 1'b0; gen_done = 1'b0;
      gen_run(4, 4'd2, 1'b1, 6'd4, 6'd3);
      wait_done(100);

      // Two trees: 19 lit symbols, then 2 dist symbols.
      push_clear(1'b0); gi_q.push_back({6'd19, 6'd5}); push_writes(1'b0, 3, 4'd3);
      push_clear(1'b1); gi_q.push_back({6'd2, 6'd9}); push_writes(1'b1, 2, 4'd1);
      dn_q.push_back(1'b0);
      do_start(6'd19, 6'd5, 1'b1, 6'd2, 6'd9);
      gen_run(3, 4'd3, 1'b1, 6'd19, 6'd5);
      t0_gd = gd_cyc;
      gen_run(2, 4'd1, 1'b1, 6'd2, 6'd9);
      wait_done(100);
      check("tree1_clear_start", sel1_clr_cyc, t0_gd + 2);

      // Hang: generator never finishes.
      push_clear(1'b0); gi_q.push_back({6'd7, 6'd2}); dn_q.push_back(1'b1);
      do_start(6'd7, 6'd2, 1'b0, 6'd0, 6'd0);
      gen_run(0, 4'd0, 1'b0, 6'd7, 6'd2);
      wait_done(5000);
      check("timeout_latency", done_cyc - gen_inc_cyc, 4096);

      // Over-subscription: 257 writes, last one suppressed.
      push_clear(1'b0); gi_q.push_back({6'd30, 6'd0}); push_writes(1'b0, 256, 4'd8); dn_q.push_back(1'b1);
      do_start(6'd30, 6'd0, 1'b0, 6'd0, 6'd0);
      gen_run(257, 4'd8, 1'b0, 6'd30, 6'd0);
      wait_done(20);
      repeat (5) @(posedge clk);
      #1;

      // Empty distance tree: cleared, never launched; err from previous job is cleared.
      push_clear(1'b0); gi_q.push_back({6'd3, 6'd4}); push_writes(1'b0, 3, 4'd5);
      push_clear(1'b1); dn_q.push_back(1'b0);
      do_start(6'd3, 6'd4, 1'b1, 6'd0, 6'd11);
      gen_run(3, 4'd5, 1'b1, 6'd3, 6'd4);
      wait_done(400);

      // Reset during BUILD; a start while busy must not re-sample cfg.
      push_clear(1'b0); gi_q.push_back({6'd4, 6'd1}); push_writes(1'b0, 2, 4'd2);
      do_start(6'd4, 6'd1, 1'b0, 6'd0, 6'd0);
      repeat (10) @(posedge clk);
      #1; lit_num = 6'd9; lit_bias = 6'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      gen_run(2, 4'd2, 1'b0, 6'd4, 6'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", int'({busy, done, err, gen_inc, gen_tree_num, gen_bias, tbl_we, tbl_sel, tbl_addr, tbl_wdata}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("reset_pending_writes", wr_q.size(), 0);
      check("reset_pending_launch", gi_q.size(), 0);
      wr_q.delete(); gi_q.delete(); dn_q.delete();
      @(posedge clk); #1;

      // Clean job after the reset.
      push_clear(1'b0); gi_q.push_back({6'd5, 6'd6}); push_writes(1'b0, 5, 4'd4); dn_q.push_back(1'b0);
      do_start(6'd5, 6'd6, 1'b0, 6'd0, 6'd0);
      gen_run(5, 4'd4, 1'b1, 6'd5, 6'd6);
      wait_done(100);
      repeat (5) @(posedge clk);
      #1;

      check("left_writes", wr_q.size(), 0);
      check("left_launches", gi_q.size(), 0);
      check("left_dones", dn_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hufftree_build_ctrl.md
Name: hufftree_build_ctrl

Overview:
- Sequences dynamic-Huffman table construction for the inflate core.
- For each tree in a job (literal/length, then optionally distance), it:
  - clears that tree's lookup table,
  - launches the tree generator with the tree's symbol count and code-length buffer bias,
  - forwards generator writes to the table write port,
  - detects completion, over-subscription and hang.
- Sits between the block-header decoder (job source) and the generator/table RAMs.

Parameters:
- HUFF_CODE_LEN, 8, max code length; table depth is 2^HUFF_CODE_LEN.
- HUFF_LEN_LEN, ceilLog2(HUFF_CODE_LEN+1), width of a code-length field.
- TIMEOUT_CYC, 4096, maximum BUILD cycles per tree before error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request pulse; sampled only in IDLE
- lit_num  in  6  symbol count, tree 0
- lit_bias  in  6  code-length buffer bias, tree 0
- dist_en  in  1  build tree 1 as well
- dist_num  in  6  symbol count, tree 1
- dist_bias  in  6  code-length buffer bias, tree 1
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle job-complete pulse
- err  out  1  sticky error flag; cleared by the next accepted start
- gen_inc  out  1  one-cycle generator launch pulse
- gen_tree_num  out  6  to generator tree_num
- gen_bias  out  6  to generator buff_addr_bias
- gen_done  in  1  generator return-to-idle pulse
- gen_winc  in  1  generator write strobe
- gen_addr  in  HUFF_CODE_LEN  generator huff_addr
- gen_len  in  HUFF_LEN_LEN  generator huff_len
- gen_code  in  5  generator huff_code
- tbl_we  out  1  table write enable
- tbl_sel  out  1  target table: 0 = lit, 1 = dist
- tbl_addr  out  HUFF_CODE_LEN  table address
- tbl_wdata  out  1+HUFF_LEN_LEN+5  {valid, len, code}

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous active-low. Reset may assert at any time, including mid-job; it aborts to IDLE with no further table writes.
- Reset values: all outputs 0; state IDLE; counters 0.
- States:
  - IDLE → CLEAR on start. Latch all cfg inputs; tree index t=0; clear err.
  - CLEAR: tbl_we=1 every cycle, tbl_wdata=0, tbl_addr = clear counter 0..2^HUFF_CODE_LEN-1. Exactly 256 cycles at default. After the last address → LAUNCH.
  - LAUNCH (1 cycle): gen_inc=1. gen_tree_num/gen_bias driven from the latched tree-t config; they hold stable from LAUNCH through BUILD. → BUILD.
  - BUILD:
    - tbl_we=gen_winc, tbl_addr=gen_addr, tbl_wdata={1,gen_len,gen_code}. Combinational pass-through, zero latency.
    - Write counter increments per gen_winc.
    - gen_done → NEXT.
    - Timeout counter reaching TIMEOUT_CYC → ERR.
    - A write while the counter already equals 2^HUFF_CODE_LEN is an over-subscribed tree → ERR. That write is suppressed (tbl_we=0).
  - NEXT (1 cycle):
    - If t=0 and dist_en: t=1 → CLEAR.
    - Otherwise → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - ERR: err=1 (sticky), done=1 for one cycle → IDLE. No wait for gen_done.
- tbl_sel = t throughout CLEAR/LAUNCH/BUILD.
- busy = state != IDLE.
- Zero symbol count (num==0): the tree is still cleared, but LAUNCH/BUILD are skipped (table stays all-invalid). CLEAR → NEXT directly.
- start while busy: ignored; cfg inputs are not re-sampled.
- gen_winc outside BUILD: ignored, no table write.
- gen_done outside BUILD: ignored.
- gen_done and gen_winc in the same cycle: the write is performed, then → NEXT.
- Incomplete tree (fewer than 2^HUFF_CODE_LEN writes): legal, no error.
- Counter widths:
  - Clear counter: HUFF_CODE_LEN+1 bits.
  - Write counter: HUFF_CODE_LEN+1 bits, saturating.
  - Timeout counter: ceilLog2(TIMEOUT_CYC+1) bits, reset on each LAUNCH.

Decomposition:
- Shared include file hufftree_defs.vh:
  - ceilLog2 function
  - state encodings (IDLE, CLEAR, LAUNCH, BUILD, NEXT, DONE, ERR)
  - tbl_wdata field offsets
- One sub-module, hufftree_tbl_clr: clear-address counter with start input, addr output and last flag. Reusable by the fixed-Huffman loader.

Test Plan:
- Single tree, lit_num=4, dist_en=0. Generator model writes 4 entries (len 2) → 256 zero writes at tbl_sel=0, one gen_inc, 4 forwarded writes with valid=1 len=2, done pulse, err=0.
- Two trees, lit_num=19, dist_num=2, dist_en=1 → second CLEAR at tbl_sel=1 starts one cycle after NEXT. gen_tree_num=2 and gen_bias=dist_bias during tree-1 BUILD. Single done pulse at the end.
- Generator model never asserts gen_done → err=1 and done exactly TIMEOUT_CYC cycles after gen_inc; busy drops the next cycle.
- Generator model issues 257 writes → the 257th write is suppressed, err=1, done pulses, no further tbl_we.
- dist_num=0 with dist_en=1 → tree-1 clear occurs, no second gen_inc, done pulses.
- rst_n low for 1 cycle during tree-0 BUILD (incl. start asserted during busy beforehand, which is ignored) → all outputs 0 immediately, IDLE; a subsequent start runs a clean job.
